// File: rtl/guess_scorer.sv
// Purpose : scores a confirmed 4-peg guess against a latched secret (exact / colour-only counts),
//           tracks turn count, win and game-over for the current game.
// Latency : done pulses in the cycle after edge T+5+NUM_COLORS (start accepted at edge T);
//           with SCORE_EARLY_WIN_EN a perfect guess finishes after edge T+5.
// Backpr. : start is ignored while busy or game_over; new_game aborts scoring and wins over start.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   new_game, secret0-3 - latch a new secret code, clear turn/win/game_over, abort scoring
//   start, guess0-3     - begin scoring the guess (pegs latched on the accepting edge)
//   busy, done          - scoring in progress / one-cycle result-valid pulse
//   exact, partial      - right colour+position / right colour, wrong position (0..4)
//   turn, win, game_over- completed turns, last guess was perfect, no more guesses allowed
// Optional: define SCORE_EARLY_WIN_EN to skip the colour phase when all four pegs match exactly.
module guess_scorer #(
    parameter int COLOR_W    = 3,
    parameter int NUM_COLORS = 8,
    parameter int MAX_TURNS  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_game,
    input  logic [COLOR_W-1:0] secret0,
    input  logic [COLOR_W-1:0] secret1,
    input  logic [COLOR_W-1:0] secret2,
    input  logic [COLOR_W-1:0] secret3,
    input  logic               start,
    input  logic [COLOR_W-1:0] guess0,
    input  logic [COLOR_W-1:0] guess1,
    input  logic [COLOR_W-1:0] guess2,
    input  logic [COLOR_W-1:0] guess3,
    output logic               busy,
    output logic               done,
    output logic [2:0]         exact,
    output logic [2:0]         partial,
    output logic [3:0]         turn,
    output logic               win,
    output logic               game_over
);

    typedef enum logic [1:0] {IDLE, EXACT, COLOR, FINISH} state_t;

    state_t             state_q, state_d;
    logic [COLOR_W-1:0] sec_q [4];
    logic [COLOR_W-1:0] gue_q [4];
    logic [1:0]         idx_q;
    logic [COLOR_W-1:0] col_q;
    logic [2:0]         exact_acc;
    logic [2:0]         total_acc;

    logic               start_ok;
    logic               exact_hit;
    logic [2:0]         exact_acc_next;
    logic [2:0]         cnt_g, cnt_s, cnt_min;
    logic               last_col;
    logic [3:0]         turn_inc;
    logic               win_next;
    logic [2:0]         partial_next;

    always_comb begin
        start_ok       = start && !game_over;
        exact_hit      = (gue_q[idx_q] == sec_q[idx_q]);
        exact_acc_next = exact_acc + 3'(exact_hit);
        cnt_g          = 3'd0;
        cnt_s          = 3'd0;
        for (int i = 0; i < 4; i++) begin
            cnt_g = cnt_g + 3'(gue_q[i] == col_q);
            cnt_s = cnt_s + 3'(sec_q[i] == col_q);
        end
        cnt_min  = (cnt_g < cnt_s) ? cnt_g : cnt_s;
        last_col = (col_q == COLOR_W'(NUM_COLORS - 1));
        turn_inc = turn + 4'd1;
        win_next = (exact_acc == 3'd4);
        // Saturating: exact matches on colours outside the legal range are not in the
        // total, and the early-win path leaves total at zero; both must yield partial=0.
        partial_next = (total_acc > exact_acc) ? (total_acc - exact_acc) : 3'd0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start_ok) state_d = EXACT;
            EXACT: begin
                if (idx_q == 2'd3) begin
`ifdef SCORE_EARLY_WIN_EN
                    state_d = (exact_acc_next == 3'd4) ? FINISH : COLOR;
`else
                    state_d = COLOR;
`endif
                end
            end
            COLOR:  if (last_col) state_d = FINISH;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (new_game) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                sec_q[i] <= '0;
                gue_q[i] <= '0;
            end
            idx_q     <= 2'd0;
            col_q     <= '0;
            exact_acc <= 3'd0;
            total_acc <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            exact     <= 3'd0;
            partial   <= 3'd0;
            turn      <= 4'd0;
            win       <= 1'b0;
            game_over <= 1'b0;
        end else if (new_game) begin
            sec_q[0]  <= secret0;
            sec_q[1]  <= secret1;
            sec_q[2]  <= secret2;
            sec_q[3]  <= secret3;
            busy      <= 1'b0;
            done      <= 1'b0;
            exact     <= 3'd0;
            partial   <= 3'd0;
            turn      <= 4'd0;
            win       <= 1'b0;
            game_over <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        gue_q[0]  <= guess0;
                        gue_q[1]  <= guess1;
                        gue_q[2]  <= guess2;
                        gue_q[3]  <= guess3;
                        idx_q     <= 2'd0;
                        col_q     <= '0;
                        exact_acc <= 3'd0;
                        total_acc <= 3'd0;
                        busy      <= 1'b1;
                    end
                end
                EXACT: begin
                    exact_acc <= exact_acc_next;
                    idx_q     <= idx_q + 2'd1;
                end
                COLOR: begin
                    total_acc <= total_acc + cnt_min;
                    col_q     <= col_q + 1'b1;
                end
                FINISH: begin
                    exact     <= exact_acc;
                    partial   <= partial_next;
                    turn      <= turn_inc;
                    win       <= win_next;
                    game_over <= win_next || (turn_inc == 4'(MAX_TURNS));
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_guess_scorer.sv
// Bench for guess_scorer: table of known scores, hand-written corner sequences
// (turn exhaustion, input stability, new_game abort, reset mid-score) and random games
// checked against a count-based Mastermind scoring model.
module tb_guess_scorer;
    localparam int CW = 3;
    localparam int NC = 8;
    localparam int MT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, new_game, start;
    logic [CW-1:0] secret0, secret1, secret2, secret3;
    logic [CW-1:0] guess0, guess1, guess2, guess3;
    logic          busy, done, win, game_over;
    logic [2:0]    exact, partial;
    logic [3:0]    turn;

    guess_scorer #(.COLOR_W(CW), .NUM_COLORS(NC), .MAX_TURNS(MT)) dut (
        .clk(clk), .reset(reset), .new_game(new_game),
        .secret0(secret0), .secret1(secret1), .secret2(secret2), .secret3(secret3),
        .start(start),
        .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
        .busy(busy), .done(done), .exact(exact), .partial(partial),
        .turn(turn), .win(win), .game_over(game_over)
    );

    int errors = 0;
    int checks = 0;

    // model state for the current game
    logic [11:0] cur_secret;
    int          m_turn;
    bit          m_win, m_go;

    typedef struct {
        logic [11:0] sec;
        logic [11:0] gue;
        int          ex;
        int          pa;
    } vec_t;

    function automatic logic [11:0] mk(input int a, input int b, input int c, input int d);
        logic [2:0] pa, pb, pc, pd;
        pa = 3'(a); pb = 3'(b); pc = 3'(c); pd = 3'(d);
        return {pd, pc, pb, pa};
    endfunction

    function automatic int peg(input logic [11:0] code, input int i);
        return int'(code[3*i +: 3]);
    endfunction

    // exact = same position; total = sum over colours of min(occurrences); partial = total - exact
    task automatic score_model(input logic [11:0] s, input logic [11:0] g,
                               output int ex, output int pa);
        int cs[NC];
        int cg[NC];
        int total;
        ex = 0; total = 0;
        for (int c = 0; c < NC; c++) begin cs[c] = 0; cg[c] = 0; end
        for (int i = 0; i < 4; i++) begin
            if (peg(s, i) == peg(g, i)) ex++;
            if (peg(s, i) < NC) cs[peg(s, i)]++;
            if (peg(g, i) < NC) cg[peg(g, i)]++;
        end
        for (int c = 0; c < NC; c++) total += (cs[c] < cg[c]) ? cs[c] : cg[c];
        pa = (total > ex) ? total - ex : 0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic drive_guess(input logic [11:0] g);
        guess0 = g[2:0]; guess1 = g[5:3]; guess2 = g[8:6]; guess3 = g[11:9];
    endtask

    task automatic new_game_cmd(input logic [11:0] s);
        secret0 = s[2:0]; secret1 = s[5:3]; secret2 = s[8:6]; secret3 = s[11:9];
        new_game = 1'b1;
        tick;
        new_game = 1'b0;
        cur_secret = s;
        m_turn = 0; m_win = 0; m_go = 0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_exact"}, exact, 0);
        chk({tag, "_partial"}, partial, 0);
        chk({tag, "_turn"}, turn, 0);
        chk({tag, "_win"}, win, 0);
        chk({tag, "_game_over"}, game_over, 0);
    endtask

    // Score one guess: g is presented at start, g_after replaces the inputs while busy.
    task automatic play(input logic [11:0] g, input logic [11:0] g_after,
                        output int ex, output int pa);
        int n, mex, mpa, lat;
        score_model(cur_secret, g, mex, mpa);
        drive_guess(g);
        start = 1'b1;
        tick;
        start = 1'b0;
        drive_guess(g_after);
        chk("busy_after_start", busy, 1);
        n = 0;
        while (!done && n < 40) begin
            tick;
            n++;
        end
        chk("done_seen", done, 1);
`ifdef SCORE_EARLY_WIN_EN
        lat = (mex == 4) ? 5 : 5 + NC;
`else
        lat = 5 + NC;
`endif
        chk("latency", n, lat);
        m_turn++;
        m_win = (mex == 4);
        m_go  = m_win || (m_turn == MT);
        chk("exact_model", exact, mex);
        chk("partial_model", partial, mpa);
        chk("turn", turn, m_turn);
        chk("win", win, m_win);
        chk("game_over", game_over, m_go);
        chk("busy_at_done", busy, 0);
        ex = exact;
        pa = partial;
        tick;
        chk("done_one_cycle", done, 0);
        chk("exact_hold", exact, mex);
    endtask

    vec_t vecs[8];

    initial begin
        int ex, pa;
        bit saw_busy, saw_done;
        logic [11:0] s, g;

        reset = 1'b1; new_game = 1'b0; start = 1'b0;
        secret0 = '0; secret1 = '0; secret2 = '0; secret3 = '0;
        drive_guess(12'h0);
        cur_secret = 12'h0; m_turn = 0; m_win = 0; m_go = 0;
        tick; tick;
        chk_cleared("reset");
        reset = 1'b0;
        tick;

        // known scores
        vecs[0] = '{mk(1,2,3,4), mk(1,2,3,4), 4, 0};
        vecs[1] = '{mk(1,1,2,2), mk(2,2,1,1), 0, 4};
        vecs[2] = '{mk(1,2,3,4), mk(1,1,1,1), 1, 0};
        vecs[3] = '{mk(5,5,0,0), mk(0,5,5,7), 1, 2};
        vecs[4] = '{mk(0,1,2,3), mk(3,2,1,0), 0, 4};
        vecs[5] = '{mk(7,7,7,7), mk(7,0,0,0), 1, 0};
        vecs[6] = '{mk(0,1,2,0), mk(0,0,1,2), 1, 3};
        vecs[7] = '{mk(6,5,4,3), mk(0,1,2,3), 1, 0};
        for (int i = 0; i < 8; i++) begin
            new_game_cmd(vecs[i].sec);
            play(vecs[i].gue, vecs[i].gue, ex, pa);
            chk($sformatf("vec%0d_exact", i), ex, vecs[i].ex);
            chk($sformatf("vec%0d_partial", i), pa, vecs[i].pa);
            chk($sformatf("vec%0d_turn", i), turn, 1);
        end

        // turn exhaustion, then a blocked 9th start
        new_game_cmd(mk(1,2,3,4));
        for (int k = 0; k < MT; k++) play(mk(0,0,0,0), mk(0,0,0,0), ex, pa);
        chk("exhaust_turn", turn, 8);
        chk("exhaust_game_over", game_over, 1);
        chk("exhaust_win", win, 0);
        drive_guess(mk(1,2,3,4));
        start = 1'b1;
        tick;
        start = 1'b0;
        saw_busy = busy; saw_done = done;
        for (int k = 0; k < 20; k++) begin
            tick;
            saw_busy |= busy;
            saw_done |= done;
        end
        chk("blocked_busy", saw_busy, 0);
        chk("blocked_done", saw_done, 0);
        chk("blocked_turn", turn, 8);

        // inputs changing while busy: latched guess 1-2-0-0 is scored
        new_game_cmd(mk(1,2,3,4));
        play(mk(1,2,0,0), mk(1,2,3,4), ex, pa);
        chk("stable_exact", ex, 2);
        chk("stable_partial", pa, 0);

        // new_game at edge T+6 aborts scoring
        drive_guess(mk(4,3,2,1));
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        secret0 = 3'd5; secret1 = 3'd5; secret2 = 3'd5; secret3 = 3'd5;
        new_game = 1'b1;
        tick;
        new_game = 1'b0;
        cur_secret = mk(5,5,5,5); m_turn = 0; m_win = 0; m_go = 0;
        chk_cleared("abort");
        saw_done = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            saw_done |= done;
        end
        chk("abort_no_done", saw_done, 0);
        play(mk(5,5,5,5), mk(5,5,5,5), ex, pa);
        chk("abort_new_secret_win", win, 1);

        // reset mid-score clears secret to 0-0-0-0
        new_game_cmd(mk(1,2,3,4));
        drive_guess(mk(1,2,3,4));
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk_cleared("midreset");
        cur_secret = 12'h0; m_turn = 0; m_win = 0; m_go = 0;
        play(mk(0,0,0,0), mk(0,0,0,0), ex, pa);
        chk("midreset_exact", ex, 4);
        chk("midreset_win", win, 1);

        // random games
        for (int gm = 0; gm < 25; gm++) begin
            s = 12'($urandom_range(0, 4095));
            new_game_cmd(s);
            for (int k = 0; k < 4; k++) begin
                if (m_go) break;
                case ($urandom_range(0, 3))
                    0: g = s;
                    1: g = {s[5:0], s[11:6]};
                    default: g = 12'($urandom_range(0, 4095));
                endcase
                play(g, 12'($urandom_range(0, 4095)), ex, pa);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
